// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB3 bridge with address-window decode and slave timeout.
// Every output is registered except req_ready, which is high only while no transfer is outstanding.
module apb_master_bridge #(
    parameter logic [31:0] ADDR_BASE = 32'h2000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        Pclk,
    input  logic        Prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] Paddr,
    output logic        Pwrite,
    output logic        Psel,
    output logic        Penable,
    output logic [31:0] Pwdata,
    input  logic [31:0] Prdata,
    input  logic        Pready,
    input  logic        Pslverr
);

    localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          accept, in_win, timed_out;

    logic [31:0]   paddr_nxt, pwdata_nxt, rsp_rdata_nxt;
    logic          pwrite_nxt, psel_nxt, penable_nxt, rsp_valid_nxt, rsp_err_nxt;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_win    = ((req_addr & ADDR_MASK) == ADDR_BASE);
    // Pready in the same cycle as the limit wins over the abort.
    assign timed_out = (TIMEOUT != 0) && (tmo_cnt == CW'(TIMEOUT)) && !Pready;

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = in_win ? SETUP : RESP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (Pready || timed_out) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        paddr_nxt     = Paddr;
        pwrite_nxt    = Pwrite;
        pwdata_nxt    = Pwdata;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        tmo_cnt_nxt   = tmo_cnt;
        psel_nxt      = (state_nxt == SETUP) || (state_nxt == ACCESS);
        penable_nxt   = (state_nxt == ACCESS);
        rsp_valid_nxt = (state_nxt == RESP);
        case (state)
            IDLE: begin
                if (accept && in_win) begin
                    paddr_nxt   = req_addr;
                    pwrite_nxt  = req_write;
                    pwdata_nxt  = req_wdata;
                    tmo_cnt_nxt = '0;
                end else if (accept) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                if (Pready) begin
                    rsp_rdata_nxt = Pwrite ? 32'h0 : Prdata;
                    rsp_err_nxt   = Pslverr;
                end else if (timed_out) begin
                    rsp_rdata_nxt = '0;
                    rsp_err_nxt   = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Pclk or posedge Prst) begin
        if (Prst) begin
            Paddr     <= '0;
            Pwrite    <= 1'b0;
            Pwdata    <= '0;
            Psel      <= 1'b0;
            Penable   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            Paddr     <= paddr_nxt;
            Pwrite    <= pwrite_nxt;
            Pwdata    <= pwdata_nxt;
            Psel      <= psel_nxt;
            Penable   <= penable_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed vector table, reset sequences and random transfers
// checked against a transfer-level model of the bridge.
module tb_apb_master_bridge;

    localparam int          TMO  = 4;
    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] MASK = 32'hFFFF_F000;

    logic        Pclk = 1'b0;
    logic        Prst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic        Pwrite, Psel, Penable, Pready, Pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Pclk = ~Pclk;

    apb_master_bridge #(.ADDR_BASE(BASE), .ADDR_MASK(MASK), .TIMEOUT(TMO)) dut (
        .Pclk(Pclk), .Prst(Prst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .Paddr(Paddr), .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable), .Pwdata(Pwdata),
        .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;   // Pready=0 cycles before the slave answers
        logic        slverr;
        logic [31:0] prd;
        int          hold;    // cycles rsp_ready is held low
        int          lat;     // expected: cycles from acceptance to rsp_valid
        logic        err;
        logic [31:0] rdata;
        int          pen;     // expected: cycles with Penable high
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transfer-level outcome of one request.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if ((v.addr & MASK) != BASE) begin
            r.lat = 1; r.err = 1'b1; r.rdata = 32'h0; r.pen = 0;
        end else if (TMO != 0 && v.waits > TMO) begin
            r.lat = 3 + TMO; r.err = 1'b1; r.rdata = 32'h0; r.pen = TMO + 1;
        end else begin
            r.lat = 3 + v.waits; r.err = v.slverr; r.rdata = v.write ? 32'h0 : v.prd; r.pen = v.waits + 1;
        end
        return r;
    endfunction

    task automatic run(input vec_t v, output int lat, output logic err, output logic [31:0] rdata,
                       output int pen, output int psel, output bit stable_ok, output bit hold_ok,
                       output bit idle_ok);
        int held;
        lat = -1; err = 1'bx; rdata = 'x; pen = 0; psel = 0;
        stable_ok = 1; hold_ok = 1; idle_ok = 0; held = 0;
        @(negedge Pclk);
        req_valid = 1'b1; req_addr = v.addr; req_write = v.write; req_wdata = v.wdata;
        rsp_ready = 1'b0; Pready = 1'b0;
        for (int c = 1; c < 64; c++) begin
            @(negedge Pclk);
            Pready = 1'b0; Pslverr = 1'b0; Prdata = $urandom;
            if (lat < 0) req_valid = 1'b0;
            if (Psel === 1'b1) begin
                psel++;
                if (Paddr !== v.addr || Pwrite !== v.write || Pwdata !== v.wdata) stable_ok = 0;
            end
            if (Penable === 1'b1) begin
                pen++;
                if (pen - 1 == v.waits) begin
                    Pready = 1'b1; Pslverr = v.slverr; Prdata = v.prd;
                end
            end
            if (rsp_valid === 1'b1) begin
                if (lat < 0) begin
                    lat = c; err = rsp_err; rdata = rsp_rdata;
                end else if (rsp_err !== err || rsp_rdata !== rdata) begin
                    hold_ok = 0;
                end
                if (req_ready !== 1'b0 || Psel !== 1'b0 || Penable !== 1'b0) hold_ok = 0;
                if (held >= v.hold) begin
                    rsp_ready = 1'b1; req_valid = 1'b0;
                    break;
                end
                held++;
                req_valid = 1'b1; req_addr = BASE; // competing request must be refused
            end
        end
        @(negedge Pclk);
        rsp_ready = 1'b0; req_valid = 1'b0; Pready = 1'b0; Pslverr = 1'b0;
        idle_ok = (rsp_valid === 1'b0 && req_ready === 1'b1 && Psel === 1'b0);
    endtask

    task automatic apply(input string tag, input vec_t v);
        int lat, pen, psel;
        logic err;
        logic [31:0] rdata;
        bit stable_ok, hold_ok, idle_ok;
        run(v, lat, err, rdata, pen, psel, stable_ok, hold_ok, idle_ok);
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".rsp_err"}, {31'h0, err}, {31'h0, v.err});
        check({tag, ".rsp_rdata"}, rdata, v.rdata);
        check({tag, ".penable_cycles"}, pen, v.pen);
        check({tag, ".psel_cycles"}, psel, (v.pen == 0) ? 0 : v.pen + 1);
        check({tag, ".apb_stable"}, {31'h0, stable_ok}, 32'h1);
        check({tag, ".rsp_hold"}, {31'h0, hold_ok}, 32'h1);
        check({tag, ".back_idle"}, {31'h0, idle_ok}, 32'h1);
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;

        //           addr          wr    wdata        waits slv   prd          hold lat err   rdata        pen
        tbl[0] = '{32'h2000_0000, 1'b1, 32'h0000_00A5, 0,    1'b0, 32'h0,        0,  3, 1'b0, 32'h0,        1};
        tbl[1] = '{32'h2000_0004, 1'b0, 32'h0,         3,    1'b0, 32'h1234_5678, 0, 6, 1'b0, 32'h1234_5678, 4};
        tbl[2] = '{32'h2000_0008, 1'b0, 32'h0,         1,    1'b1, 32'hDEAD_BEEF, 0, 4, 1'b1, 32'hDEAD_BEEF, 2};
        tbl[3] = '{32'h2000_000C, 1'b1, 32'h5555_AAAA, 0,    1'b1, 32'h7777_7777, 0, 3, 1'b1, 32'h0,        1};
        tbl[4] = '{32'h3000_0000, 1'b0, 32'h0,         0,    1'b0, 32'h1111_1111, 0, 1, 1'b1, 32'h0,        0};
        tbl[5] = '{32'h2000_0010, 1'b0, 32'h0,         1000, 1'b0, 32'h2222_2222, 0, 7, 1'b1, 32'h0,        5};
        tbl[6] = '{32'h2000_0014, 1'b0, 32'h0,         4,    1'b0, 32'hCAFE_F00D, 0, 7, 1'b0, 32'hCAFE_F00D, 5};
        tbl[7] = '{32'h2000_0018, 1'b1, 32'h0BAD_F00D, 3,    1'b0, 32'h3333_3333, 0, 6, 1'b0, 32'h0,        4};
        tbl[8] = '{32'h2000_1000, 1'b1, 32'h4444_4444, 0,    1'b0, 32'h0,        0,  1, 1'b1, 32'h0,        0};
        tbl[9] = '{32'h2000_0FFC, 1'b0, 32'h0,         0,    1'b0, 32'h8765_4321, 5, 3, 1'b0, 32'h8765_4321, 1};

        Prst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        rsp_ready = 1'b0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        repeat (2) @(negedge Pclk);
        Prst = 1'b0;
        @(negedge Pclk);
        check("reset.req_ready", {31'h0, req_ready}, 32'h1);
        check("reset.psel_penable", {30'h0, Psel, Penable}, 32'h0);
        check("reset.paddr", Paddr, 32'h0);
        check("reset.pwdata", Pwdata, 32'h0);
        check("reset.pwrite", {31'h0, Pwrite}, 32'h0);
        check("reset.rsp", {30'h0, rsp_valid, rsp_err}, 32'h0);
        check("reset.rsp_rdata", rsp_rdata, 32'h0);

        for (int i = 0; i < 10; i++) apply($sformatf("vec%0d", i), tbl[i]);

        // Reset asserted in the middle of an ACCESS phase.
        @(negedge Pclk);
        req_valid = 1'b1; req_addr = 32'h2000_0020; req_write = 1'b0;
        @(negedge Pclk);
        req_valid = 1'b0;
        @(negedge Pclk);
        check("midrst.in_access", {30'h0, Psel, Penable}, 32'h3);
        #2 Prst = 1'b1;
        #1;
        check("midrst.apb_drop", {30'h0, Psel, Penable}, 32'h0);
        check("midrst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge Pclk);
        Prst = 1'b0;
        repeat (2) @(negedge Pclk);
        check("midrst.req_ready", {31'h0, req_ready}, 32'h1);
        check("midrst.still_idle", {29'h0, rsp_valid, Psel, Penable}, 32'h0);
        apply("post_rst", tbl[0]);

        for (int i = 0; i < 40; i++) begin
            v.addr   = ($urandom_range(0, 3) == 0) ? $urandom : (BASE | ($urandom & ~MASK));
            v.write  = 1'($urandom_range(0, 1));
            v.wdata  = $urandom;
            v.waits  = ($urandom_range(0, 5) == 0) ? 100 : int'($urandom_range(0, 5));
            v.slverr = ($urandom_range(0, 3) == 0);
            v.prd    = $urandom;
            v.hold   = int'($urandom_range(0, 2));
            v = model(v);
            apply($sformatf("rnd%0d", i), v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
